ldo_pt_controller: RTL and testbench

//  Digital control loop for the DLDO power-transistor (PT) array. Samples the clocked comparator

---
 rtl/ldo_pt_controller_if.sv | 25 ++
 rtl/ldo_pt_controller.sv | 174 +++++++++++++++++
 tb/tb_ldo_pt_controller.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ldo_pt_controller_if.sv
// Comparator-side inputs and PT-array-side outputs of the DLDO control loop.
// The master modport drives the loop inputs; the slave modport is the controller.
interface ldo_pt_controller_if #(
    parameter int ARRSZ = 9
);
    logic             en;
    logic [1:0]       mode_sel;
    logic             cmp_in;
    logic             std_ctrl_in;
    logic [ARRSZ-1:0] std_pt_in_cnt;
    logic [ARRSZ-1:0] pt_cnt;
    logic             lock;
    logic             sat;
    logic [1:0]       state;

    modport master (
        output en, mode_sel, cmp_in, std_ctrl_in, std_pt_in_cnt,
        input  pt_cnt, lock, sat, state
    );

    modport slave (
        input  en, mode_sel, cmp_in, std_ctrl_in, std_pt_in_cnt,
        output pt_cnt, lock, sat, state
    );
endinterface

// File: rtl/ldo_pt_controller.sv
// DLDO PT-count loop: soft-start ramp, coarse/fine tracking, limit-cycle lock, test-mode mux.
// Latency: one cycle from sample to pt_cnt; no backpressure, a new sample is taken every cycle.
module ldo_pt_controller #(
    parameter int ARRSZ    = 9,
    parameter int NPT      = 511,
    parameter int SS_DIV   = 4,
    parameter int COARSE_N = 4,
    parameter int STEP_C   = 8,
    parameter int LOCK_N   = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    ldo_pt_controller_if.slave   bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SSTART = 2'd1;
    localparam logic [1:0] S_TRACK  = 2'd2;
    localparam logic [1:0] S_LOCK   = 2'd3;

    localparam int W    = ARRSZ + 1;
    localparam int RUNW = $clog2(COARSE_N + 1) + 1;
    localparam int ALTW = $clog2(LOCK_N + 1);
    localparam int DIVW = (SS_DIV > 1) ? $clog2(SS_DIV) : 1;

    localparam logic [ARRSZ-1:0] NPT_P    = ARRSZ'(NPT);
    localparam logic [ARRSZ-1:0] PT_ONE   = ARRSZ'(1);
    localparam logic [W-1:0]     NPT_W    = W'(NPT);
    localparam logic [W-1:0]     STEP_W   = W'(STEP_C);
    localparam logic [W-1:0]     FINE_W   = W'(1);
    localparam logic [RUNW-1:0]  RUN_ONE  = RUNW'(1);
    localparam logic [RUNW-1:0]  RUN_TWO  = RUNW'(2);
    localparam logic [RUNW-1:0]  RUN_MAX  = '1;
    localparam logic [RUNW-1:0]  COARSE_R = RUNW'(COARSE_N);
    localparam logic [ALTW-1:0]  ALT_ONE  = ALTW'(1);
    localparam logic [ALTW-1:0]  ALT_MAX  = '1;
    localparam logic [ALTW-1:0]  LOCK_A   = ALTW'(LOCK_N);
    localparam logic [DIVW-1:0]  DIV_ONE  = DIVW'(1);
    localparam logic [DIVW-1:0]  DIV_LAST = DIVW'(SS_DIV - 1);

    logic [1:0]       r_state;
    logic [ARRSZ-1:0] r_pt;
    logic             r_lock;
    logic             r_sat;
    logic [RUNW-1:0]  r_run;
    logic [ALTW-1:0]  r_alt;
    logic [DIVW-1:0]  r_div;
    logic             r_prev_d;
    logic [1:0]       r_grp;

    logic [1:0]       w_grp;
    logic             w_d;
    logic             w_same;
    logic             w_abort;
    logic [RUNW-1:0]  w_run_nxt;
    logic [ALTW-1:0]  w_alt_nxt;
    logic [W-1:0]     w_step;
    logic [W-1:0]     w_sum;
    logic [W-1:0]     w_diff;
    logic             w_up_clamp;
    logic             w_dn_clamp;
    logic [ARRSZ-1:0] w_pt_loop;
    logic             w_clamp;
    logic [ARRSZ-1:0] w_pt_direct;

    // 10 and 11 share a group so switching between them does not restart the loop
    assign w_grp  = bus.mode_sel[1] ? 2'd2 : {1'b0, bus.mode_sel[0]};
    assign w_d    = (bus.mode_sel == 2'b01) ? bus.std_ctrl_in : bus.cmp_in;
    assign w_same = (w_d == r_prev_d);
    assign w_abort = (r_state != S_IDLE) && (!bus.en || (w_grp != r_grp));

    assign w_run_nxt = !w_same            ? RUN_ONE :
                       (r_run == RUN_MAX) ? r_run   : r_run + RUN_ONE;
    assign w_alt_nxt = w_same             ? '0      :
                       (r_alt == ALT_MAX) ? r_alt   : r_alt + ALT_ONE;

    // Coarse step uses the run length including the current sample; LOCK is always fine
    assign w_step = ((r_state == S_TRACK) && (w_run_nxt >= COARSE_R)) ? STEP_W : FINE_W;

    assign w_sum      = {1'b0, r_pt} + w_step;
    assign w_diff     = {1'b0, r_pt} - w_step;
    assign w_up_clamp = (w_sum > NPT_W);
    assign w_dn_clamp = w_diff[ARRSZ];
    assign w_clamp    = w_d ? w_up_clamp : w_dn_clamp;
    assign w_pt_loop  = w_d ? (w_up_clamp ? NPT_P : w_sum[ARRSZ-1:0])
                            : (w_dn_clamp ? '0    : w_diff[ARRSZ-1:0]);

    assign w_pt_direct = (bus.std_pt_in_cnt > NPT_P) ? NPT_P : bus.std_pt_in_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_pt     <= '0;
            r_lock   <= 1'b0;
            r_sat    <= 1'b0;
            r_run    <= '0;
            r_alt    <= '0;
            r_div    <= '0;
            r_prev_d <= 1'b0;
            r_grp    <= 2'd0;
        end else begin
            r_grp    <= w_grp;
            r_prev_d <= w_d;
            r_sat    <= 1'b0;
            if (bus.mode_sel == 2'b00) begin
                r_state <= S_IDLE;
                r_pt    <= w_pt_direct;
                r_lock  <= 1'b0;
                r_run   <= '0;
                r_alt   <= '0;
                r_div   <= '0;
            end else if (w_abort) begin
                r_state <= S_IDLE;
                r_pt    <= '0;
                r_lock  <= 1'b0;
                r_run   <= '0;
                r_alt   <= '0;
                r_div   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_pt   <= '0;
                        r_lock <= 1'b0;
                        r_run  <= '0;
                        r_alt  <= '0;
                        r_div  <= '0;
                        if (bus.en) begin
                            r_state <= S_SSTART;
                        end
                    end
                    S_SSTART: begin
                        r_run <= RUN_ONE;
                        r_alt <= '0;
                        if (!w_d || (r_pt == NPT_P)) begin
                            r_state <= S_TRACK;
                        end else if (r_div == DIV_LAST) begin
                            r_pt  <= r_pt + PT_ONE;
                            r_div <= '0;
                        end else begin
                            r_div <= r_div + DIV_ONE;
                        end
                    end
                    S_TRACK: begin
                        r_pt  <= w_pt_loop;
                        r_sat <= w_clamp;
                        r_run <= w_run_nxt;
                        r_alt <= w_alt_nxt;
                        if (w_alt_nxt >= LOCK_A) begin
                            r_state <= S_LOCK;
                            r_lock  <= 1'b1;
                        end
                    end
                    default: begin
                        r_pt  <= w_pt_loop;
                        r_sat <= w_clamp;
                        if (w_same) begin
                            r_state <= S_TRACK;
                            r_lock  <= 1'b0;
                            r_run   <= RUN_TWO;
                            r_alt   <= '0;
                        end else begin
                            r_run <= w_run_nxt;
                            r_alt <= w_alt_nxt;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.pt_cnt = r_pt;
    assign bus.lock   = r_lock;
    assign bus.sat    = r_sat;
    assign bus.state  = r_state;
endmodule

// File: tb/tb_ldo_pt_controller.sv
// Directed-vector bench for ldo_pt_controller with a queue scoreboard; a second
// instance with NPT=300 sits permanently in mode 00 to cover the direct-count clamp.
module tb_ldo_pt_controller;
    localparam int ARRSZ = 9;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ldo_pt_controller_if #(.ARRSZ(ARRSZ)) bus ();
    ldo_pt_controller_if #(.ARRSZ(ARRSZ)) bus_b ();

    ldo_pt_controller #(
        .ARRSZ(ARRSZ), .NPT(511), .SS_DIV(4), .COARSE_N(4), .STEP_C(8), .LOCK_N(6)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    ldo_pt_controller #(
        .ARRSZ(ARRSZ), .NPT(300), .SS_DIV(4), .COARSE_N(4), .STEP_C(8), .LOCK_N(6)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    typedef struct packed {
        logic [8:0] pt;
        logic       lock;
        logic       sat;
        logic [1:0] state;
        logic [8:0] pt_b;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_entry = 0;

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s entry %0d: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    // Monitor: outputs are valid every cycle and also right after an async reset
    initial begin : monitor
        exp_t e;
        #3;
        forever begin
            @(posedge clk or negedge reset);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("pt_cnt", n_entry, int'(bus.pt_cnt), int'(e.pt));
                chk("lock",   n_entry, int'(bus.lock),   int'(e.lock));
                chk("sat",    n_entry, int'(bus.sat),    int'(e.sat));
                chk("state",  n_entry, int'(bus.state),  int'(e.state));
                chk("pt_cnt_npt300", n_entry, int'(bus_b.pt_cnt), int'(e.pt_b));
                n_entry++;
            end
        end
    end

    task automatic step(input logic e, input logic [1:0] m, input logic c, input logic s,
                        input logic [8:0] std, input logic [8:0] xpt, input logic xl,
                        input logic xs, input logic [1:0] xst);
        exp_t x;
        @(negedge clk);
        bus.en                = e;
        bus.mode_sel          = m;
        bus.cmp_in            = c;
        bus.std_ctrl_in       = s;
        bus.std_pt_in_cnt     = std;
        bus_b.std_pt_in_cnt   = std;
        x.pt    = xpt;
        x.lock  = xl;
        x.sat   = xs;
        x.state = xst;
        x.pt_b  = !reset ? 9'd0 : ((std > 9'd300) ? 9'd300 : std);
        sb_q.push_back(x);
    endtask

    task automatic s01(input logic s, input logic [8:0] xpt, input logic xl,
                       input logic xs, input logic [1:0] xst);
        step(1'b1, 2'b01, 1'b0, s, 9'd0, xpt, xl, xs, xst);
    endtask

    task automatic async_reset_check();
        exp_t x;
        @(negedge clk);
        x = '0;
        sb_q.push_back(x);
        reset = 1'b0;
    endtask

    initial begin : stim
        bus.en = 1'b0;           bus.mode_sel = 2'b00;
        bus.cmp_in = 1'b0;       bus.std_ctrl_in = 1'b0;
        bus.std_pt_in_cnt = '0;
        bus_b.en = 1'b1;         bus_b.mode_sel = 2'b00;
        bus_b.cmp_in = 1'b0;     bus_b.std_ctrl_in = 1'b0;
        bus_b.std_pt_in_cnt = '0;

        // Reset values
        step(0, 2'b00, 0, 0, 9'd0, 9'd0, 0, 0, 2'd0);
        step(0, 2'b00, 0, 0, 9'd0, 9'd0, 0, 0, 2'd0);
        @(negedge clk);
        reset = 1'b1;

        // Mode 00: direct count, clamped to NPT
        step(1, 2'b00, 0, 0, 9'd3,   9'd3,   0, 0, 2'd0);
        step(1, 2'b00, 0, 0, 9'd511, 9'd511, 0, 0, 2'd0);
        step(1, 2'b00, 0, 0, 9'd299, 9'd299, 0, 0, 2'd0);
        step(1, 2'b00, 0, 0, 9'd300, 9'd300, 0, 0, 2'd0);

        // Mode 10 soft-start ramp all the way to NPT, then saturation in TRACK
        step(1, 2'b10, 1, 0, 9'd0, 9'd0, 0, 0, 2'd1);
        for (int k = 1; k <= 2044; k++) begin
            step(1, 2'b10, 1, 0, 9'd0, 9'(k / 4), 0, 0, 2'd1);
        end
        step(1, 2'b10, 1, 0, 9'd0, 9'd511, 0, 0, 2'd2);
        step(1, 2'b10, 1, 0, 9'd0, 9'd511, 0, 1, 2'd2);
        step(1, 2'b10, 1, 0, 9'd0, 9'd511, 0, 1, 2'd2);
        step(1, 2'b10, 1, 0, 9'd0, 9'd511, 0, 1, 2'd2);

        // en=0 aborts to IDLE
        step(0, 2'b10, 1, 0, 9'd0, 9'd0, 0, 0, 2'd0);

        // Mode 01: short ramp driven by std_ctrl_in while cmp_in stays 0
        s01(1, 9'd0, 0, 0, 2'd1);
        s01(1, 9'd0, 0, 0, 2'd1);
        s01(1, 9'd0, 0, 0, 2'd1);
        s01(1, 9'd0, 0, 0, 2'd1);
        s01(1, 9'd1, 0, 0, 2'd1);
        s01(0, 9'd1, 0, 0, 2'd2);
        // Ten 1s: fine, fine, fine, then coarse
        s01(1, 9'd2,  0, 0, 2'd2);
        s01(1, 9'd3,  0, 0, 2'd2);
        s01(1, 9'd4,  0, 0, 2'd2);
        s01(1, 9'd12, 0, 0, 2'd2);
        s01(1, 9'd20, 0, 0, 2'd2);
        s01(1, 9'd28, 0, 0, 2'd2);
        s01(1, 9'd36, 0, 0, 2'd2);
        s01(1, 9'd44, 0, 0, 2'd2);
        s01(1, 9'd52, 0, 0, 2'd2);
        s01(1, 9'd60, 0, 0, 2'd2);
        s01(0, 9'd59, 0, 0, 2'd2);
        // Alternation builds to lock on the sixth change
        s01(1, 9'd60, 0, 0, 2'd2);
        s01(0, 9'd59, 0, 0, 2'd2);
        s01(1, 9'd60, 0, 0, 2'd2);
        s01(0, 9'd59, 0, 0, 2'd2);
        s01(1, 9'd60, 1, 0, 2'd3);
        s01(0, 9'd59, 1, 0, 2'd3);
        // Two equal samples leave LOCK with run count 2: next is fine, then coarse
        s01(0, 9'd58, 0, 0, 2'd2);
        s01(0, 9'd57, 0, 0, 2'd2);
        s01(0, 9'd49, 0, 0, 2'd2);
        s01(0, 9'd41, 0, 0, 2'd2);
        s01(0, 9'd33, 0, 0, 2'd2);
        s01(0, 9'd25, 0, 0, 2'd2);
        s01(0, 9'd17, 0, 0, 2'd2);
        s01(0, 9'd9,  0, 0, 2'd2);
        s01(0, 9'd1,  0, 0, 2'd2);
        // Coarse step below zero clamps at 0 without wrapping
        s01(0, 9'd0,  0, 1, 2'd2);
        s01(0, 9'd0,  0, 1, 2'd2);
        s01(1, 9'd1,  0, 0, 2'd2);
        s01(1, 9'd2,  0, 0, 2'd2);
        s01(1, 9'd3,  0, 0, 2'd2);
        s01(1, 9'd11, 0, 0, 2'd2);
        s01(1, 9'd19, 0, 0, 2'd2);
        s01(1, 9'd27, 0, 0, 2'd2);
        s01(1, 9'd35, 0, 0, 2'd2);

        // Async reset mid-TRACK takes effect before the next clock edge
        async_reset_check();
        step(0, 2'b01, 0, 0, 9'd0, 9'd0, 0, 0, 2'd0);
        @(negedge clk);
        reset = 1'b1;

        // 10<->11 is not a group change; 01 is
        step(1, 2'b11, 0, 0, 9'd0, 9'd0, 0, 0, 2'd1);
        step(1, 2'b11, 0, 0, 9'd0, 9'd0, 0, 0, 2'd2);
        step(1, 2'b11, 0, 0, 9'd0, 9'd0, 0, 1, 2'd2);
        step(1, 2'b10, 1, 0, 9'd0, 9'd1, 0, 0, 2'd2);
        step(1, 2'b11, 1, 0, 9'd0, 9'd2, 0, 0, 2'd2);
        step(1, 2'b01, 1, 1, 9'd0, 9'd0, 0, 0, 2'd0);

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
            @(posedge clk);
        end
        #2;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
